// File: rtl/decode_stage.sv
// Single-entry decode stage: holds one fetched word, decodes its register
// operands and jump class combinationally, and stalls on load-use hazards.
module decode_stage #(
  parameter int          REG_W    = 4,
  parameter int          CNT_W    = 8,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [15:0]      if_instr,
  output logic             if_ready,
  input  logic             flush,
  input  logic             ld_valid,
  input  logic [REG_W-1:0] ld_dst,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [15:0]      id_instr,
  output logic [REG_W-1:0] id_rs,
  output logic [REG_W-1:0] id_rm,
  output logic [REG_W-1:0] id_rt,
  output logic [2:0]       id_use,
  output logic [2:0]       id_jump,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [REG_W-1:0] R_IH = REG_W'(8);
  localparam logic [REG_W-1:0] R_SP = REG_W'(9);
  localparam logic [REG_W-1:0] R_RA = REG_W'(10);

  localparam logic [2:0] J_IDLE = 3'd0;
  localparam logic [2:0] J_EQZ  = 3'd1;
  localparam logic [2:0] J_NEZ  = 3'd2;
  localparam logic [2:0] J_TEQZ = 3'd3;
  localparam logic [2:0] J_TNEZ = 3'd4;
  localparam logic [2:0] J_JUMP = 3'd5;
  localparam logic [2:0] J_DB   = 3'd6;

  logic [15:0]      w;
  logic             f;
  logic             hazard;
  logic [REG_W-1:0] fa, fb, fc;

  assign fa = REG_W'(w[10:8]);
  assign fb = REG_W'(w[7:5]);
  assign fc = REG_W'(w[4:2]);

  // Operand/jump decode of the held word; id_use is {T,M,S}
  always_comb begin
    id_rs   = '0;
    id_rm   = '0;
    id_rt   = '0;
    id_use  = 3'b000;
    id_jump = J_IDLE;
    case (w[15:11])
      5'b00000: begin id_rs = R_SP; id_rt = fa; id_use = 3'b101; end
      5'b00010: id_jump = J_DB;
      5'b00100: begin id_rs = fa; id_use = 3'b001; id_jump = J_EQZ; end
      5'b00101: begin id_rs = fa; id_use = 3'b001; id_jump = J_NEZ; end
      5'b00110,
      5'b01111: begin id_rs = fb; id_rt = fa; id_use = 3'b101; end
      5'b01000: begin id_rs = fa; id_rt = fb; id_use = 3'b101; end
      5'b01001: begin id_rs = fa; id_rt = fa; id_use = 3'b101; end
      5'b01010,
      5'b01011,
      5'b01110: begin id_rs = fa; id_use = 3'b001; end
      5'b01101: begin id_rt = fa; id_use = 3'b100; end
      5'b10010: begin id_rm = R_SP; id_rt = fa; id_use = 3'b110; end
      5'b10011: begin id_rm = fa; id_rt = fb; id_use = 3'b110; end
      5'b11010: begin id_rs = fa; id_rm = R_SP; id_use = 3'b011; end
      5'b11011: begin id_rs = fb; id_rm = fa; id_use = 3'b011; end
      5'b11100: begin id_rs = fa; id_rm = fb; id_rt = fc; id_use = 3'b111; end
      5'b01100: begin
        case (w[10:8])
          3'd0: id_jump = J_TEQZ;
          3'd1: id_jump = J_TNEZ;
          3'd2: begin id_rs = R_RA; id_rm = R_SP; id_use = 3'b011; end
          3'd3: begin id_rs = R_SP; id_rt = R_SP; id_use = 3'b101; end
          3'd4: begin id_rs = fb; id_rt = R_SP; id_use = 3'b101; end
          default: ;
        endcase
      end
      5'b11101: begin
        case (w[4:0])
          5'b00000: begin
            case (w[7:5])
              3'd0: begin id_rs = fa; id_use = 3'b001; id_jump = J_JUMP; end
              3'd1: begin id_rs = R_RA; id_use = 3'b001; id_jump = J_JUMP; end
              3'd2: begin id_rt = fa; id_use = 3'b100; end
              3'd6: begin id_rs = fa; id_rt = R_RA; id_use = 3'b101; id_jump = J_JUMP; end
              default: ;
            endcase
          end
          5'b00010,
          5'b00011: begin id_rs = fa; id_rm = fb; id_use = 3'b011; end
          5'b00100,
          5'b00110,
          5'b00111: begin id_rs = fb; id_rm = fa; id_rt = fb; id_use = 3'b111; end
          5'b01010: begin id_rs = fb; id_rm = fa; id_use = 3'b011; end
          5'b01011,
          5'b01111: begin id_rs = fb; id_rt = fa; id_use = 3'b101; end
          5'b01100,
          5'b01101,
          5'b01110: begin id_rs = fb; id_rm = fa; id_rt = fa; id_use = 3'b111; end
          default: ;
        endcase
      end
      5'b11110: begin
        if (w[0]) begin id_rs = fa; id_rt = R_IH; end
        else      begin id_rs = R_IH; id_rt = fa; end
        id_use = 3'b101;
      end
      default: ;
    endcase
  end

  // Only sources can collide with an in-flight load; the destination never stalls
  assign hazard   = f & ld_valid & ((id_use[0] & (id_rs == ld_dst)) |
                                    (id_use[1] & (id_rm == ld_dst)));
  assign id_valid = f & ~hazard;
  assign if_ready = ~flush & (~f | (id_ready & ~hazard));
  assign id_instr = w;

  // Holding register: flush beats a fetch, a fetch beats a plain drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w <= NOP_WORD;
      f <= 1'b0;
    end else if (flush) begin
      w <= NOP_WORD;
      f <= 1'b0;
    end else if (if_valid && if_ready) begin
      w <= if_instr;
      f <= 1'b1;
    end else if (id_valid && id_ready) begin
      f <= 1'b0;
    end
  end

  // Saturating count of cycles lost to load-use stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hazard && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: spec-level model plus directed vectors.
module tb_decode_stage;
  localparam int RW = 4;

  logic          clk, rst, if_valid, flush, ld_valid, id_ready;
  logic [15:0]   if_instr;
  logic [RW-1:0] ld_dst;

  logic          if_ready, id_valid;
  logic [15:0]   id_instr;
  logic [RW-1:0] id_rs, id_rm, id_rt;
  logic [2:0]    id_use, id_jump;
  logic [7:0]    stall_cnt;

  logic          s_if_ready, s_id_valid;
  logic [15:0]   s_id_instr;
  logic [RW-1:0] s_id_rs, s_id_rm, s_id_rt;
  logic [2:0]    s_id_use, s_id_jump;
  logic [1:0]    s_stall_cnt;

  int n_tot = 0;
  int n_pass = 0;

  decode_stage u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .flush(flush), .ld_valid(ld_valid), .ld_dst(ld_dst), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_rs(id_rs), .id_rm(id_rm), .id_rt(id_rt),
    .id_use(id_use), .id_jump(id_jump), .stall_cnt(stall_cnt)
  );

  decode_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_ready(s_if_ready),
    .flush(flush), .ld_valid(ld_valid), .ld_dst(ld_dst), .id_valid(s_id_valid),
    .id_ready(id_ready), .id_instr(s_id_instr), .id_rs(s_id_rs), .id_rm(s_id_rm), .id_rt(s_id_rt),
    .id_use(s_id_use), .id_jump(s_id_jump), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // operand selectors used by the model
  localparam int N = 0, A = 1, B = 2, C = 3, SP = 4, RA = 5, IH = 6;

  function automatic int fld(input logic [15:0] w, input int sel);
    case (sel)
      A:  return int'(w[10:8]);
      B:  return int'(w[7:5]);
      C:  return int'(w[4:2]);
      SP: return 9;
      RA: return 10;
      IH: return 8;
      default: return 0;
    endcase
  endfunction

  // instruction table: which field feeds S, M, T and the jump class
  function automatic void sel_of(input logic [15:0] w, output int s, output int m,
                                 output int t, output int j);
    int op, a, b, lo;
    op = int'(w[15:11]); a = int'(w[10:8]); b = int'(w[7:5]); lo = int'(w[4:0]);
    s = N; m = N; t = N; j = 0;
    if (op == 0) begin s = SP; t = A; end
    else if (op == 2) j = 6;
    else if (op == 4) begin s = A; j = 1; end
    else if (op == 5) begin s = A; j = 2; end
    else if (op == 6 || op == 15) begin s = B; t = A; end
    else if (op == 8) begin s = A; t = B; end
    else if (op == 9) begin s = A; t = A; end
    else if (op == 10 || op == 11 || op == 14) s = A;
    else if (op == 13) t = A;
    else if (op == 18) begin m = SP; t = A; end
    else if (op == 19) begin m = A; t = B; end
    else if (op == 26) begin s = A; m = SP; end
    else if (op == 27) begin s = B; m = A; end
    else if (op == 28) begin s = A; m = B; t = C; end
    else if (op == 12) begin
      if (a == 0) j = 3;
      else if (a == 1) j = 4;
      else if (a == 2) begin s = RA; m = SP; end
      else if (a == 3) begin s = SP; t = SP; end
      else if (a == 4) begin s = B; t = SP; end
    end else if (op == 29) begin
      if (lo == 0) begin
        if (b == 0) begin s = A; j = 5; end
        else if (b == 1) begin s = RA; j = 5; end
        else if (b == 2) t = A;
        else if (b == 6) begin s = A; t = RA; j = 5; end
      end
      else if (lo == 2 || lo == 3) begin s = A; m = B; end
      else if (lo == 4 || lo == 6 || lo == 7) begin s = B; m = A; t = B; end
      else if (lo == 10) begin s = B; m = A; end
      else if (lo == 11 || lo == 15) begin s = B; t = A; end
      else if (lo >= 12 && lo <= 14) begin s = B; m = A; t = A; end
    end else if (op == 30) begin
      if (w[0]) begin s = A; t = IH; end
      else begin s = IH; t = A; end
    end
  endfunction

  function automatic void mexp(input logic [15:0] w, output int rs, output int rm,
                               output int rt, output int u, output int j);
    int s, m, t;
    sel_of(w, s, m, t, j);
    rs = fld(w, s); rm = fld(w, m); rt = fld(w, t);
    u = ((t != N) ? 4 : 0) + ((m != N) ? 2 : 0) + ((s != N) ? 1 : 0);
  endfunction

  // model state
  logic        m_full;
  logic [15:0] m_word;
  int          m_cnt, m_cnt2;

  function automatic logic m_hazard();
    int rs, rm, rt, u, j;
    mexp(m_word, rs, rm, rt, u, j);
    return m_full && ld_valid && ((u[0] && rs == int'(ld_dst)) || (u[1] && rm == int'(ld_dst)));
  endfunction

  function automatic logic m_ifready();
    return !flush && (!m_full || (id_ready && !m_hazard()));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_full <= 1'b0; m_word <= 16'h0800; m_cnt <= 0; m_cnt2 <= 0;
    end else begin
      if (m_hazard() && !flush) begin
        if (m_cnt < 255) m_cnt <= m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
      end
      if (flush) begin
        m_full <= 1'b0; m_word <= 16'h0800;
      end else if (if_valid && m_ifready()) begin
        m_full <= 1'b1; m_word <= if_instr;
      end else if (m_full && !m_hazard() && id_ready) begin
        m_full <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int rs, rm, rt, u, j;
    logic hz;
    mexp(m_word, rs, rm, rt, u, j);
    hz = m_hazard();
    chk("id_valid", id_valid, m_full && !hz);
    chk("if_ready", if_ready, m_ifready());
    chk("id_instr", id_instr, m_word);
    chk("id_rs", id_rs, rs);
    chk("id_rm", id_rm, rm);
    chk("id_rt", id_rt, rt);
    chk("id_use", id_use, u);
    chk("id_jump", id_jump, j);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("sat_stall_cnt", s_stall_cnt, m_cnt2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] words [40];

  initial begin
    words = '{16'h0300, 16'h1000, 16'h2100, 16'h2A00, 16'h3640, 16'h4520, 16'h4A00, 16'h5300,
              16'h5800, 16'h7100, 16'h6E00, 16'h7DA0, 16'h9600, 16'h9C40, 16'hD400, 16'hDBE0,
              16'hE368, 16'hEA00, 16'h6000, 16'h6100, 16'h6200, 16'h6300, 16'h64A0, 16'h6500,
              16'hE920, 16'hE840, 16'hEFC0, 16'hE860, 16'hE842, 16'hE847, 16'hE84A, 16'hE84B,
              16'hE84F, 16'hE84C, 16'hE84E, 16'hE845, 16'hF300, 16'hF301, 16'h8000, 16'hFFFF};
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; flush = 1'b0;
    ld_valid = 1'b0; ld_dst = '0; id_ready = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_id_instr", id_instr, 16'h0800);
    chk("rst_id_use", id_use, 0);
    chk("rst_id_jump", id_jump, 0);
    chk("rst_stall", stall_cnt, 0);
    step(); step();
    rst = 1'b1;

    // addu r3,r3 -> r2 appears one cycle after fetch
    if_valid = 1'b1; if_instr = 16'hE368; id_ready = 1'b1;
    step();
    if_valid = 1'b0;
    @(negedge clk);
    chk("addu_valid", id_valid, 1);
    chk("addu_rs", id_rs, 3);
    chk("addu_rm", id_rm, 3);
    chk("addu_rt", id_rt, 2);
    chk("addu_use", id_use, 3'b111);
    step();

    // lw then jr held
    id_ready = 1'b0; if_valid = 1'b1; if_instr = 16'h9C40;
    step();
    if_valid = 1'b0;
    @(negedge clk);
    chk("lw_rs", id_rs, 0);
    chk("lw_rm", id_rm, 4);
    chk("lw_rt", id_rt, 2);
    chk("lw_use", id_use, 3'b110);
    id_ready = 1'b1; if_valid = 1'b1; if_instr = 16'hEA00;
    step();
    if_valid = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    chk("jr_rs", id_rs, 2);
    chk("jr_jump", id_jump, 5);
    chk("jr_use", id_use, 3'b001);

    // load-use hazard on r3, with a fetch offered but refused
    id_ready = 1'b1; if_valid = 1'b1; if_instr = 16'hE368;
    step();
    ld_valid = 1'b1; ld_dst = 4'd3; if_instr = 16'h1234;
    step(); step(); step();
    @(negedge clk);
    chk("hz_id_valid", id_valid, 0);
    chk("hz_if_ready", if_ready, 0);
    chk("hz_stall3", stall_cnt, 3);
    chk("hz_sat3", s_stall_cnt, 3);
    chk("hz_held", id_instr, 16'hE368);
    step(); step(); step();
    @(negedge clk);
    chk("hz_stall6", stall_cnt, 6);
    chk("hz_sat_hold", s_stall_cnt, 3);
    ld_dst = 4'd2; if_valid = 1'b0;
    #1;
    chk("dst_only_no_hz", id_valid, 1);
    ld_valid = 1'b0;
    step();

    // flush during a hazard drops the held and the offered word
    id_ready = 1'b0; if_valid = 1'b1; if_instr = 16'h9C40;
    step();
    ld_valid = 1'b1; ld_dst = 4'd4; flush = 1'b1; if_instr = 16'h1234;
    @(negedge clk);
    chk("flush_if_ready", if_ready, 0);
    step();
    flush = 1'b0; if_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", id_valid, 0);
    chk("flush_instr", id_instr, 16'h0800);
    chk("flush_stall", stall_cnt, 6);

    // back-to-back stream, downstream always ready
    id_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if_valid = 1'b1; if_instr = words[i];
      step();
    end
    if_valid = 1'b0;
    step();

    // stream with backpressure and load traffic
    for (int i = 0; i < 40; i++) begin
      if_valid = (i % 4 != 3); if_instr = words[39 - i];
      id_ready = (i % 3 != 0);
      ld_valid = (i % 2 == 1); ld_dst = 4'(i % 16);
      step();
    end
    if_valid = 1'b0; ld_valid = 1'b0; id_ready = 1'b0;
    step();

    // asynchronous reset with a word held
    if_valid = 1'b1; if_instr = 16'hE368; ld_valid = 1'b1; ld_dst = 4'd3;
    step();
    if_valid = 1'b0;
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", id_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", id_valid, 0);
    chk("async_rst_stall", stall_cnt, 0);
    chk("async_rst_instr", id_instr, 16'h0800);
    step();
    rst = 1'b1;
    if_valid = 1'b1; if_instr = 16'h9C40;
    step();
    if_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_instr", id_instr, 16'h9C40);
    chk("post_rst_valid", id_valid, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter REG_W, default 4, register-index width (legal values 4..6).
REQ-002 SHALL have parameter CNT_W, default 8, stall-counter width.
REQ-003 SHALL have parameter NOP_WORD, default 16'h0800, bubble instruction.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 if_valid  input  1  fetch offers if_instr.
REQ-007 if_instr  input  16  fetched instruction.
REQ-008 if_ready  output  1  decode accepts if_instr this cycle.
REQ-009 flush  input  1  branch redirect; discard held instruction.
REQ-010 ld_valid  input  1  execute stage holds a load (lw, lw_sp).
REQ-011 ld_dst  input  REG_W  destination index of that load.
REQ-012 id_valid  output  1  decoded instruction presented downstream.
REQ-013 id_ready  input  1  downstream accepts.
REQ-014 id_instr  output  16  held instruction word.
REQ-015 id_rs, id_rm, id_rt  output  REG_W each  source S, source M, destination T indices.
REQ-016 id_use  output  3  use flags {T,M,S}; an index is meaningful only when its flag is 1.
REQ-017 id_jump  output  3  IDLE=0, EQZ=1, NEZ=2, TEQZ=3, TNEZ=4, JUMP=5, DB=6.
REQ-018 stall_cnt  output  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-019 Decode state SHALL be a one-entry register: held word W plus full bit F.
REQ-020 Fields: A=W[10:8], B=W[7:5], C=W[4:2], zero-extended to REG_W; SP=9, RA=10, IH=8.
REQ-021 Decode (S,M,T) SHALL be: 00000 (SP,-,A); 00010 jump DB; 00100 (A,-,-) EQZ; 00101 (A,-,-) NEZ; 00110 (B,-,A); 01000 (A,-,B); 01001 (A,-,A); 01010/01011/01110 (A,-,-); 01101 (-,-,A); 01111 (B,-,A); 10010 (-,SP,A); 10011 (-,A,B); 11010 (A,SP,-); 11011 (B,A,-); 11100 (A,B,C).
REQ-022 Opcode 01100 by A-field value: 0 TEQZ; 1 TNEZ; 2 (RA,SP,-); 3 (SP,-,SP); 4 (B,-,SP).
REQ-023 Opcode 11101 by W[4:0]: 00000 with B=0 (A,-,-) JUMP, B=1 (RA,-,-) JUMP, B=2 (-,-,A), B=6 (A,-,RA) JUMP; 00010/00011 (A,B,-); 00100/00110/00111 (B,A,B); 01010 (B,A,-); 01011/01111 (B,-,A); 01100/01101/01110 (B,A,A).
REQ-024 Opcode 11110: W[0]=0 (IH,-,A), W[0]=1 (A,-,IH).
REQ-025 "-" and all unlisted encodings SHALL drive index 0 with use flag 0; jump IDLE unless stated.
REQ-026 Decode outputs SHALL be combinational from W, so decode latency is 0 cycles after W loads; fetch-to-id_valid latency is 1 cycle.
REQ-027 hazard = F and ld_valid and ((use S and id_rs==ld_dst) or (use M and id_rm==ld_dst)).
REQ-028 id_valid = F and not hazard.
REQ-029 if_ready = not F, or (id_ready and not hazard); forced 0 while flush=1.
REQ-030 Load: if_valid and if_ready -> W<=if_instr, F<=1; else if id_valid and id_ready -> F<=0, W unchanged.
REQ-031 flush=1 SHALL win over all: W<=NOP_WORD, F<=0, concurrent fetch word dropped.
REQ-032 stall_cnt SHALL increment each cycle hazard=1 and flush=0, saturating at all-ones.
REQ-033 Back-to-back transfers SHALL sustain one instruction per cycle with no hazard.

Reset
REQ-034 rst=0 SHALL asynchronously set W=NOP_WORD, F=0, stall_cnt=0; hence id_valid=0, id_use=0, indices 0, id_jump=IDLE, if_ready=1.
REQ-035 Reset mid-transfer SHALL discard the held instruction; first accept after release is a fresh load.

Verification
REQ-036 if_valid=1, if_instr=16'hE368 (addu A=3,B=3,C=2), id_ready=1 -> next cycle id_valid=1, rs=3, rm=3, rt=2, id_use=3'b111.
REQ-037 Held 16'h9C40 (lw A=4,B=2) -> rs=0, rm=4, rt=2, use=3'b110; held 16'hEA00 (jr r2) -> rs=2, jump=5.
REQ-038 Held 16'hE368, ld_valid=1, ld_dst=3 for 3 cycles -> id_valid=0, if_ready=0, stall_cnt=3; ld_valid=0 -> id_valid=1.
REQ-039 flush=1 with if_valid=1 and F=1 -> next cycle F=0, id_instr=16'h0800, new word not captured.
REQ-040 CNT_W=2, hazard held 6 cycles -> stall_cnt stays at 3 after 3 cycles.
REQ-041 rst pulsed low mid-stream with F=1 -> immediate id_valid=0, stall_cnt=0, id_instr=16'h0800.
